// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-master round-robin arbiter onto one synchronous-read
// memory port, with configurable read latency and address/alignment errors.
//
// Ports:
//   clock, reset                 rising-edge clock, sync active-high reset
//   m_req_i/m_we_i               per-master request and write enable
//   m_addr_i/m_wdata_i           flattened per-master byte address / data
//   m_rdata_o/m_ack_o/m_err_o    shared read data, one-hot ack, error flag
//   mem_addr_o/mem_wdata_o       memory word address and write data
//   mem_we_o/mem_rdata_i         memory write strobe and read data
//   busy_o                       high while a transaction is in flight
module mem_arbiter_rr #(
    parameter int NUM_MASTERS      = 2,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int SLAVE_ADDR_WIDTH = 8,
    parameter int MEM_LATENCY      = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_MASTERS-1:0]           m_req_i,
    input  logic [NUM_MASTERS-1:0]           m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [DATA_WIDTH-1:0]            m_rdata_o,
    output logic [NUM_MASTERS-1:0]           m_ack_o,
    output logic [NUM_MASTERS-1:0]           m_err_o,
    output logic [SLAVE_ADDR_WIDTH-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_wdata_o,
    output logic                             mem_we_o,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
    output logic                             busy_o
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(MEM_LATENCY + 1);
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_MASTERS - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [GW-1:0]               r_grant;
    logic [GW-1:0]               r_last;
    logic [GW-1:0]               w_pick;
    logic                        w_found;
    logic                        r_we;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [DATA_WIDTH-1:0]       r_wdata;
    logic [DATA_WIDTH-1:0]       r_rdata;
    logic [CW-1:0]               r_cnt;
    logic                        w_err;
    logic [SLAVE_ADDR_WIDTH-1:0] w_word;
    logic [NUM_MASTERS-1:0]      w_onehot;

    // Misaligned, or any byte-address bit above the memory's reach is set.
    assign w_err    = (r_addr[1:0] != 2'b00) ||
                      ((r_addr >> (SLAVE_ADDR_WIDTH + 2)) != '0);
    assign w_word   = r_addr[SLAVE_ADDR_WIDTH+1:2];
    assign w_onehot = NUM_MASTERS'(1) << r_grant;
    assign busy_o   = (r_state != S_IDLE);

    // Rotating priority: scan starts one past the last granted master.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!w_found && m_req_i[(int'(r_last) + i) % NUM_MASTERS]) begin
                w_found = 1'b1;
                w_pick  = GW'((int'(r_last) + i) % NUM_MASTERS);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        m_ack_o     = '0;
        m_err_o     = '0;
        m_rdata_o   = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) w_next = S_ACCESS;
            end
            S_ACCESS: begin
                mem_addr_o = w_word;
                if (r_we && !w_err) begin
                    mem_we_o    = 1'b1;
                    mem_wdata_o = r_wdata;
                end
                w_next = (r_we || w_err) ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                mem_addr_o = w_word;
                if (r_cnt == CNT_ONE) w_next = S_RESP;
            end
            S_RESP: begin
                m_ack_o = w_onehot;
                m_err_o = w_err ? w_onehot : '0;
                if (!r_we && !w_err) m_rdata_o = r_rdata;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= LAST_RST;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_we    <= m_we_i[w_pick];
                        r_addr  <= m_addr_i[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata <= m_wdata_i[w_pick*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                S_ACCESS: begin
                    if (!r_we && !w_err) r_cnt <= CNT_LOAD;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) r_rdata <= mem_rdata_i;
                end
                S_RESP: begin
                    r_last <= r_grant;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed and randomized bench for mem_arbiter_rr
// with a transaction-level reference model and latency-pipelined memory.
module tb_mem_arbiter_rr;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 8;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_we = '0;
    logic [N*AW-1:0] m_addr = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_err;
    logic [SW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_we;
    logic            busy;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr #(
        .NUM_MASTERS(N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .SLAVE_ADDR_WIDTH(SW),
        .MEM_LATENCY(LAT)
    ) dut (
        .clock(clk),
        .reset(reset),
        .m_req_i(m_req),
        .m_we_i(m_we),
        .m_addr_i(m_addr),
        .m_wdata_i(m_wdata),
        .m_rdata_o(m_rdata),
        .m_ack_o(m_ack),
        .m_err_o(m_err),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata),
        .busy_o(busy)
    );

    // Memory slave: data appears LAT cycles after the address cycle.
    logic [DW-1:0] smem [256];
    logic [DW-1:0] pipe [LAT];
    logic [DW-1:0] emem [256];

    always @(posedge clk) begin
        if (mem_we) smem[mem_addr] <= mem_wdata;
        pipe[0] <= smem[mem_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Transaction-level reference model.
    bit           mdl_on = 0;
    bit           m_busy = 0;
    int           m_age, m_ackat, m_last, t_g, wrd;
    logic         t_we, t_err;
    logic [31:0]  t_addr, t_data;
    logic [N-1:0] e_ack, e_err, ack_seen;
    logic [31:0]  e_rd;
    logic         e_we, e_busy, e_addr_v;
    int           wcnt [N];

    always @(negedge clk) begin
        if (mdl_on) begin
            e_ack = '0; e_err = '0; e_rd = '0;
            e_we = 1'b0; e_busy = 1'b0; e_addr_v = 1'b0;
            wrd = 0;
            if (m_busy) begin
                m_age++;
                e_busy = 1'b1;
                wrd = (t_addr / 4) % 256;
                if (m_age < m_ackat) e_addr_v = 1'b1;
                if (m_age == 1 && t_we && !t_err) e_we = 1'b1;
                if (m_age == m_ackat) begin
                    e_ack[t_g] = 1'b1;
                    e_err[t_g] = t_err;
                    if (!t_we && !t_err) e_rd = emem[wrd];
                end
            end
            chk("mdl_busy", 32'(busy), 32'(e_busy));
            chk("mdl_ack", 32'(m_ack), 32'(e_ack));
            chk("mdl_err", 32'(m_err), 32'(e_err));
            chk("mdl_rdata", m_rdata, e_rd);
            chk("mdl_we", 32'(mem_we), 32'(e_we));
            if (e_addr_v) chk("mdl_addr", 32'(mem_addr), 32'(wrd));
            if (e_we) begin
                chk("mdl_wdata", mem_wdata, t_data);
                emem[wrd] = t_data;
            end
            if (m_busy && m_age == m_ackat) begin
                m_last = t_g;
                m_busy = 0;
            end else if (!m_busy && m_req != '0) begin
                t_g = -1;
                for (int i = 1; i <= N; i++) begin
                    if (t_g < 0 && m_req[(m_last + i) % N]) t_g = (m_last + i) % N;
                end
                for (int k = 0; k < N; k++) begin
                    if (k == t_g || !m_req[k]) wcnt[k] = 0;
                    else begin
                        wcnt[k]++;
                        chk("fair_wait", 32'(wcnt[k] <= N - 1), 32'd1);
                    end
                end
                t_we   = m_we[t_g];
                t_addr = m_addr[t_g*AW +: AW];
                t_data = m_wdata[t_g*DW +: DW];
                t_err  = (t_addr % 4 != 0) || (t_addr >= 1024);
                m_ackat = (t_we || t_err) ? 2 : 2 + LAT;
                m_age  = 0;
                m_busy = 1;
            end
            if (reset) begin
                m_busy = 0;
                m_last = N - 1;
                for (int k = 0; k < N; k++) wcnt[k] = 0;
            end
        end
        if (reset) begin
            mdl_on = 1;
            m_busy = 0;
            m_last = N - 1;
            for (int k = 0; k < N; k++) wcnt[k] = 0;
        end
        ack_seen = m_ack;
    end

    task automatic do_reset();
        reset = 1'b1;
        m_req = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Single transaction from master k; starts in an IDLE cycle at posedge+1.
    task automatic do_txn(input int k, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input int exp_cyc,
                          input logic exp_err, input logic [31:0] exp_rd,
                          input string nm, output int we_cnt,
                          output logic [31:0] addr1);
        int cyc;
        bit got;
        m_req[k] = 1'b1;
        m_we[k] = we;
        m_addr[k*AW +: AW] = a;
        m_wdata[k*DW +: DW] = d;
        cyc = 0; got = 0; we_cnt = 0; addr1 = '0;
        while (!got && cyc < 50) begin
            @(negedge clk);
            we_cnt += int'(mem_we);
            if (cyc == 1) addr1 = 32'(mem_addr);
            if (m_ack[k]) begin
                got = 1;
                chk({nm, "_cycle"}, 32'(cyc), 32'(exp_cyc));
                chk({nm, "_ackvec"}, 32'(m_ack), 32'(1) << k);
                chk({nm, "_err"}, 32'(m_err[k]), 32'(exp_err));
                chk({nm, "_rdata"}, m_rdata, exp_rd);
            end else begin
                cyc++;
            end
        end
        if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        m_req[k] = 1'b0;
    endtask

    int ord [16];
    int nord;

    // Masters in mask request valid reads; keep=1 holds req after ack.
    task automatic group(input logic [N-1:0] mask, input int ntx,
                         input bit keep);
        int cyc;
        logic [N-1:0] drop;
        for (int k = 0; k < N; k++) begin
            if (mask[k]) begin
                m_req[k] = 1'b1;
                m_we[k] = 1'b0;
                m_addr[k*AW +: AW] = 32'(k * 4);
            end
        end
        nord = 0; cyc = 0;
        while (nord < ntx && cyc < 200) begin
            @(negedge clk);
            cyc++;
            drop = '0;
            if (m_ack != '0) begin
                chk("grp_onehot", 32'($countones(m_ack)), 32'd1);
                for (int k = 0; k < N; k++) begin
                    if (m_ack[k] && nord < 16) begin
                        ord[nord] = k;
                        nord++;
                        if (!keep) drop[k] = 1'b1;
                    end
                end
            end
            @(posedge clk);
            #1;
            m_req = m_req & ~drop;
        end
        if (nord < ntx) chk("grp_timeout", 32'(nord), 32'(ntx));
        m_req = m_req & ~mask;
    endtask

    int we_cnt, nack;
    logic [31:0] a1, ra;
    logic [7:0] w8;
    int exp4 [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        for (int i = 0; i < 256; i++) begin
            smem[i] = 32'h5A5A0000 | 32'(i);
            emem[i] = 32'h5A5A0000 | 32'(i);
        end
        for (int i = 0; i < LAT; i++) pipe[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(m_ack), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1;

        do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0, "wr0",
               we_cnt, a1);
        chk("wr0_we_pulses", 32'(we_cnt), 32'd1);
        chk("wr0_addr", a1, 32'h04);

        do_txn(1, 1'b0, 32'h10, 32'h0, 2 + LAT, 1'b0, 32'hDEADBEEF, "rd1",
               we_cnt, a1);
        chk("rd1_we_pulses", 32'(we_cnt), 32'd0);

        do_txn(0, 1'b0, 32'h402, 32'h0, 2, 1'b1, 32'h0, "mis",
               we_cnt, a1);
        chk("mis_we_pulses", 32'(we_cnt), 32'd0);
        do_txn(0, 1'b0, 32'h400, 32'h0, 2, 1'b1, 32'h0, "oor",
               we_cnt, a1);
        chk("oor_we_pulses", 32'(we_cnt), 32'd0);
        do_txn(2, 1'b1, 32'h401, 32'h55, 2, 1'b1, 32'h0, "werr",
               we_cnt, a1);
        chk("werr_we_pulses", 32'(we_cnt), 32'd0);

        do_reset();
        group(4'b1111, 6, 1'b1);
        for (int i = 0; i < 6; i++) chk("rr_order", 32'(ord[i]), 32'(exp4[i]));

        // Reset during WAIT of a read.
        m_req[2] = 1'b1;
        m_we[2] = 1'b0;
        m_addr[2*AW +: AW] = 32'h30;
        nack = 0;
        repeat (2) begin
            @(negedge clk);
            nack += $countones(m_ack);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        m_req[2] = 1'b0;
        @(negedge clk);
        nack += $countones(m_ack);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rw_no_ack", 32'(nack + $countones(m_ack)), 32'd0);
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_we", 32'(mem_we), 32'd0);
        chk("rw_rdata", m_rdata, 32'd0);
        chk("rw_addr", 32'(mem_addr), 32'd0);
        @(posedge clk);
        #1;
        group(4'b1001, 2, 1'b0);
        chk("rw_first", 32'(ord[0]), 32'd0);
        chk("rw_second", 32'(ord[1]), 32'd3);

        do_txn(0, 1'b1, 32'h20, 32'h1234, 2, 1'b0, 32'h0, "wr0b",
               we_cnt, a1);
        group(4'b0011, 2, 1'b0);
        chk("tie_first", 32'(ord[0]), 32'd1);
        chk("tie_second", 32'(ord[1]), 32'd0);

        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                m_req = '0;
            end else begin
                reset = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (ack_seen[k]) m_req[k] = 1'b0;
                    if (!m_req[k] && $urandom_range(0, 2) == 0) begin
                        w8 = 8'($urandom);
                        case ($urandom_range(0, 9))
                            8: ra = {22'd0, w8, 2'($urandom_range(1, 3))};
                            9: ra = $urandom | 32'h400;
                            default: ra = {22'd0, w8, 2'b00};
                        endcase
                        m_req[k] = 1'b1;
                        m_we[k] = 1'($urandom);
                        m_addr[k*AW +: AW] = ra;
                        m_wdata[k*DW +: DW] = $urandom;
                    end else if (m_req[k] && $urandom_range(0, 199) == 0) begin
                        m_req[k] = 1'b0;
                    end
                end
            end
        end
        reset = 1'b0;
        m_req = '0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
